// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and the data-memory responder.
// The master drives the request side; the slave returns ready, busy and the response.
interface dmem_responder_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              busy;
    logic              rsp_valid;
    logic [63:0]       rsp_rdata;
    logic [3:0]        rsp_stat;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, busy, rsp_valid, rsp_rdata, rsp_stat
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, busy, rsp_valid, rsp_rdata, rsp_stat
    );
endinterface

// File: rtl/dmem_responder.sv
// Y86 data-memory responder: one 64-bit little-endian read/write per request, ADR status on bad address.
// Latency: rsp_valid pulses LATENCY cycles after accept; DMEM_ALIGN_CHECK_EN also faults unaligned words.
// Backpressure: one request in flight; req_ready low from accept through the response cycle.
module dmem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2,
    parameter int ADDR_W    = 64
) (
    input  logic           i_clk,
    input  logic           i_reset,
    dmem_responder_if.slave io_bus
);
    localparam int         AW       = $clog2(MEM_BYTES);
    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_ADR = 4'b0010;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_ready;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;
    logic [63:0]       r_rdata;
    logic [3:0]        r_stat;
    logic [7:0]        r_mem [MEM_BYTES];

    state_t            w_next;
    logic [3:0]        w_cnt_nxt;
    logic              w_accept;
    logic              w_enter_resp;
    logic              w_write;
    logic [ADDR_W-1:0] w_addr;
    logic [63:0]       w_wdata;
    logic [AW-1:0]     w_base;
    logic              w_adr;
    logic [63:0]       w_rd;

    assign w_accept = io_bus.req_valid & r_ready;

    // With LATENCY=1 RESP is entered on the accept edge itself, so use the live request there.
    assign w_addr  = (r_state == S_IDLE) ? io_bus.req_addr  : r_addr;
    assign w_write = (r_state == S_IDLE) ? io_bus.req_write : r_write;
    assign w_wdata = (r_state == S_IDLE) ? io_bus.req_wdata : r_wdata;
    assign w_base  = w_addr[AW-1:0];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_adr = (w_addr > ADDR_W'(MEM_BYTES - 8)) | (w_addr[2:0] != 3'd0);
`else
    assign w_adr = (w_addr > ADDR_W'(MEM_BYTES - 8));
`endif

    always_comb begin
        w_rd = '0;
        for (int k = 0; k < 8; k++) begin
            w_rd[8*k +: 8] = r_mem[w_base + AW'(k)];
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_next = S_RESP;
                    end else begin
                        w_next    = S_WAIT;
                        w_cnt_nxt = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next    = S_RESP;
                    w_cnt_nxt = 4'd0;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_stat  <= STAT_AOK;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_next == S_IDLE);
            if (w_accept) begin
                r_write <= io_bus.req_write;
                r_addr  <= io_bus.req_addr;
                r_wdata <= io_bus.req_wdata;
            end
            if (w_enter_resp) begin
                r_rdata <= (w_write || w_adr) ? 64'd0 : w_rd;
                r_stat  <= w_adr ? STAT_ADR : STAT_AOK;
            end
        end
    end

    // Array is deliberately not reset; a reset on the commit edge cancels the write.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_enter_resp && w_write && !w_adr) begin
            for (int k = 0; k < 8; k++) begin
                r_mem[w_base + AW'(k)] <= w_wdata[8*k +: 8];
            end
        end
    end

    assign io_bus.req_ready = r_ready;
    assign io_bus.busy      = (r_state != S_IDLE);
    assign io_bus.rsp_valid = (r_state == S_RESP);
    assign io_bus.rsp_rdata = r_rdata;
    assign io_bus.rsp_stat  = r_stat;
endmodule
